mips_multicycle_control: RTL and testbench

//  Main control FSM for the multicycle MIPS datapath. Sequences PC, instruction register, memory,

---
 rtl/mips_multicycle_control_if.sv | 38 +++
 rtl/mips_multicycle_control.sv | 168 ++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// master = controller side, slave = datapath side.
interface mips_multicycle_control_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal_op;

    // Memory handshake: mem_read/mem_write stay asserted while waiting;
    // mem_ready high in a cycle means the access completed at that clock edge.
    modport master (
        input  op, funct, mem_ready,
        output pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_src, illegal_op
    );

    modport slave (
        output op, funct, mem_ready,
        input  pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_src, illegal_op
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath (R-type/jr, lw, sw, beq, bne, addi, j, jal).
// Outputs are decoded from the state register; only FETCH gates ir_write/pc_write with mem_ready.
module mips_multicycle_control #(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    mips_multicycle_control_if.master  ctl,
    output logic [3:0]                 state
);
    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEM_ADR = 4'd3,
        S_MEM_RD  = 4'd4,
        S_MEM_WB  = 4'd5,
        S_MEM_WR  = 4'd6,
        S_EXEC    = 4'd7,
        S_ALU_WB  = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11,
        S_JUMP    = 4'd12,
        S_JR      = 4'd13,
        S_HALT    = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_t     state_q;
    state_t     state_d;
    logic [5:0] op_q;

    // op is captured in DECODE so later states ignore any change on the op pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RESET;
            op_q    <= 6'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= ctl.op;
            end
        end
    end

    assign state = state_q;

    always_comb begin
        state_d           = state_q;
        ctl.pc_write      = 1'b0;
        ctl.pc_write_cond = 1'b0;
        ctl.branch_ne     = 1'b0;
        ctl.i_or_d        = 1'b0;
        ctl.mem_read      = 1'b0;
        ctl.mem_write     = 1'b0;
        ctl.ir_write      = 1'b0;
        ctl.reg_dst       = 2'b00;
        ctl.mem_to_reg    = 2'b00;
        ctl.reg_write     = 1'b0;
        ctl.alu_src_a     = 1'b0;
        ctl.alu_src_b     = 2'b00;
        ctl.alu_op        = 2'b00;
        ctl.pc_src        = 2'b00;
        ctl.illegal_op    = 1'b0;

        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = 2'b01;
                ctl.ir_write  = ctl.mem_ready;
                ctl.pc_write  = ctl.mem_ready;
                if (ctl.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch target computed speculatively into ALUOut.
                ctl.alu_src_b = 2'b11;
                case (ctl.op)
                    OP_LW, OP_SW:   state_d = S_MEM_ADR;
                    OP_RTYPE:       state_d = S_EXEC;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI:        state_d = S_ADDI_EX;
                    OP_J, OP_JAL:   state_d = S_JUMP;
                    default: begin
                        ctl.illegal_op = 1'b1;
                        state_d        = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_MEM_ADR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
                state_d       = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                ctl.i_or_d   = 1'b1;
                ctl.mem_read = 1'b1;
                if (ctl.mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                ctl.mem_to_reg = 2'b01;
                ctl.reg_write  = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEM_WR: begin
                ctl.i_or_d    = 1'b1;
                ctl.mem_write = 1'b1;
                if (ctl.mem_ready) state_d = S_FETCH;
            end
            S_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = 2'b10;
                state_d       = (ctl.funct == FN_JR) ? S_JR : S_ALU_WB;
            end
            S_ALU_WB: begin
                ctl.reg_dst   = 2'b01;
                ctl.reg_write = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_op        = 2'b01;
                ctl.pc_src        = 2'b01;
                ctl.pc_write_cond = 1'b1;
                ctl.branch_ne     = (op_q == OP_BNE);
                state_d           = S_FETCH;
            end
            S_ADDI_EX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
                state_d       = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                ctl.reg_write = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                ctl.pc_src   = 2'b10;
                ctl.pc_write = 1'b1;
                // jal links the already-incremented PC into r31.
                if (op_q == OP_JAL) begin
                    ctl.reg_write  = 1'b1;
                    ctl.reg_dst    = 2'b10;
                    ctl.mem_to_reg = 2'b10;
                end
                state_d = S_FETCH;
            end
            S_JR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = 2'b10;
                ctl.pc_write  = 1'b1;
                state_d       = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: two instances (HALT_ON_ILLEGAL 0 and 1) share stimulus;
// the driver queues expected per-cycle vectors and a negedge monitor compares them.
module tb_mips_multicycle_control;
    localparam logic [3:0] S_RESET = 4'd0,  S_FETCH = 4'd1,   S_DECODE = 4'd2, S_MEM_ADR = 4'd3,
                           S_MEM_RD = 4'd4, S_MEM_WB = 4'd5,  S_MEM_WR = 4'd6, S_EXEC = 4'd7,
                           S_ALU_WB = 4'd8, S_BRANCH = 4'd9,  S_ADDI_EX = 4'd10, S_ADDI_WB = 4'd11,
                           S_JUMP = 4'd12,  S_JR = 4'd13,     S_HALT = 4'd14;
    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011, OP_BEQ = 6'b000100,
                           OP_BNE = 6'b000101, OP_ADDI = 6'b001000, OP_LW = 6'b100011,
                           OP_SW = 6'b101011, OP_ILL = 6'b111111;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] st_a;
    logic [3:0] st_b;
    logic [5:0] fn_cur;
    logic       halted2;
    int         checks = 0;
    int         errors = 0;

    logic [27:0] exp_q[$];
    string       name_q[$];

    mips_multicycle_control_if ifa ();
    mips_multicycle_control_if ifb ();

    assign ifb.op        = ifa.op;
    assign ifb.funct     = ifa.funct;
    assign ifb.mem_ready = ifa.mem_ready;

    mips_multicycle_control #(.HALT_ON_ILLEGAL(1'b0)) dut_a (.clk(clk), .rst(rst), .ctl(ifa), .state(st_a));
    mips_multicycle_control #(.HALT_ON_ILLEGAL(1'b1)) dut_b (.clk(clk), .rst(rst), .ctl(ifb), .state(st_b));

    always #5 clk = ~clk;

    function automatic logic is_legal(input logic [5:0] op);
        return (op == OP_R) || (op == OP_J) || (op == OP_JAL) || (op == OP_BEQ) || (op == OP_BNE) ||
               (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    endfunction

    // Control vector {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write,
    // reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op}.
    function automatic logic [19:0] exp_ctl(input logic [3:0] st, input logic [5:0] iop, input logic mr);
        logic pw, pwc, bne, iod, mrd, mwr, irw, rw, sa, ill;
        logic [1:0] rd, m2r, sb, aop, psrc;
        {pw, pwc, bne, iod, mrd, mwr, irw, rw, sa, ill} = '0;
        {rd, m2r, sb, aop, psrc} = '0;
        case (st)
            S_FETCH:   begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
            S_DECODE:  begin sb = 2'b11; ill = !is_legal(iop); end
            S_MEM_ADR: begin sa = 1; sb = 2'b10; end
            S_MEM_RD:  begin iod = 1; mrd = 1; end
            S_MEM_WB:  begin m2r = 2'b01; rw = 1; end
            S_MEM_WR:  begin iod = 1; mwr = 1; end
            S_EXEC:    begin sa = 1; aop = 2'b10; end
            S_ALU_WB:  begin rd = 2'b01; rw = 1; end
            S_BRANCH:  begin sa = 1; aop = 2'b01; psrc = 2'b01; pwc = 1; bne = (iop == OP_BNE); end
            S_ADDI_EX: begin sa = 1; sb = 2'b10; end
            S_ADDI_WB: begin rw = 1; end
            S_JUMP:    begin psrc = 2'b10; pw = 1;
                             if (iop == OP_JAL) begin rw = 1; rd = 2'b10; m2r = 2'b10; end end
            S_JR:      begin sa = 1; aop = 2'b10; pw = 1; end
            default:   ;
        endcase
        return {pw, pwc, bne, iod, mrd, mwr, irw, rd, m2r, rw, sa, sb, aop, psrc, ill};
    endfunction

    // One clock cycle: drive pins, queue what both instances must show during this cycle.
    task automatic cyc(input logic r, input logic [5:0] op_pin, input logic mr, input logic [3:0] st,
                       input logic [5:0] iop, input string name, input bit chk);
        logic [3:0] st2;
        rst           = r;
        ifa.op        = op_pin;
        ifa.funct     = fn_cur;
        ifa.mem_ready = mr;
        st2 = (halted2 && st != S_RESET) ? S_HALT : st;
        if (chk) begin
            exp_q.push_back({st2, st, exp_ctl(st, iop, mr)});
            name_q.push_back(name);
        end
        @(posedge clk);
        #1;
        if (st == S_RESET) halted2 = 1'b0;
        if (st == S_DECODE && !is_legal(iop)) halted2 = 1'b1;
    endtask

    task automatic step(input logic [3:0] st, input logic [5:0] iop, input logic mr, input string name);
        cyc(1'b0, iop, mr, st, iop, name, 1'b1);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [27:0] exp_v;
            logic [27:0] act_v;
            string       nm;
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act_v = {st_b, st_a, ifa.pc_write, ifa.pc_write_cond, ifa.branch_ne, ifa.i_or_d,
                     ifa.mem_read, ifa.mem_write, ifa.ir_write, ifa.reg_dst, ifa.mem_to_reg,
                     ifa.reg_write, ifa.alu_src_a, ifa.alu_src_b, ifa.alu_op, ifa.pc_src, ifa.illegal_op};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", nm, act_v, exp_v);
            end
        end
    end

    initial begin
        halted2 = 1'b0;
        fn_cur  = 6'd0;
        cyc(1'b1, OP_R, 1'b0, S_RESET, OP_R, "rst_first", 1'b0);
        cyc(1'b1, OP_R, 1'b0, S_RESET, OP_R, "rst_hold", 1'b1);
        cyc(1'b0, OP_R, 1'b1, S_RESET, OP_R, "rst_release", 1'b1);

        step(S_FETCH, OP_LW, 1'b1, "lw_fetch");
        step(S_DECODE, OP_LW, 1'b1, "lw_decode");
        step(S_MEM_ADR, OP_LW, 1'b1, "lw_memadr");
        step(S_MEM_RD, OP_LW, 1'b1, "lw_memrd");
        step(S_MEM_WB, OP_LW, 1'b1, "lw_memwb");

        step(S_FETCH, OP_SW, 1'b1, "sw_fetch");
        step(S_DECODE, OP_SW, 1'b1, "sw_decode");
        cyc(1'b0, OP_LW, 1'b1, S_MEM_ADR, OP_SW, "sw_memadr_op_change", 1'b1);
        for (int i = 0; i < 3; i++) step(S_MEM_WR, OP_SW, 1'b0, "sw_memwr_wait");
        step(S_MEM_WR, OP_SW, 1'b1, "sw_memwr_done");
        step(S_FETCH, OP_SW, 1'b0, "fetch_wait_a");
        step(S_FETCH, OP_SW, 1'b0, "fetch_wait_b");

        fn_cur = 6'b100000;
        step(S_FETCH, OP_R, 1'b1, "add_fetch");
        step(S_DECODE, OP_R, 1'b1, "add_decode");
        step(S_EXEC, OP_R, 1'b1, "add_exec");
        step(S_ALU_WB, OP_R, 1'b1, "add_alu_wb");

        fn_cur = 6'b001000;
        step(S_FETCH, OP_R, 1'b1, "jr_fetch");
        step(S_DECODE, OP_R, 1'b1, "jr_decode");
        step(S_EXEC, OP_R, 1'b1, "jr_exec");
        step(S_JR, OP_R, 1'b1, "jr_pc");
        fn_cur = 6'd0;

        step(S_FETCH, OP_BNE, 1'b1, "bne_fetch");
        step(S_DECODE, OP_BNE, 1'b1, "bne_decode");
        cyc(1'b0, OP_BEQ, 1'b1, S_BRANCH, OP_BNE, "bne_branch_op_change", 1'b1);
        step(S_FETCH, OP_BEQ, 1'b1, "beq_fetch");
        step(S_DECODE, OP_BEQ, 1'b1, "beq_decode");
        step(S_BRANCH, OP_BEQ, 1'b1, "beq_branch");

        step(S_FETCH, OP_ADDI, 1'b1, "addi_fetch");
        step(S_DECODE, OP_ADDI, 1'b1, "addi_decode");
        step(S_ADDI_EX, OP_ADDI, 1'b1, "addi_ex");
        step(S_ADDI_WB, OP_ADDI, 1'b1, "addi_wb");

        step(S_FETCH, OP_J, 1'b1, "j_fetch");
        step(S_DECODE, OP_J, 1'b1, "j_decode");
        step(S_JUMP, OP_J, 1'b1, "j_jump");
        step(S_FETCH, OP_JAL, 1'b1, "jal_fetch");
        step(S_DECODE, OP_JAL, 1'b1, "jal_decode");
        step(S_JUMP, OP_JAL, 1'b1, "jal_jump");

        step(S_FETCH, OP_ILL, 1'b1, "ill_fetch");
        step(S_DECODE, OP_ILL, 1'b1, "ill_decode");
        step(S_FETCH, OP_LW, 1'b1, "after_ill_fetch");
        step(S_DECODE, OP_LW, 1'b1, "after_ill_decode");
        step(S_MEM_ADR, OP_LW, 1'b1, "after_ill_memadr");
        step(S_MEM_RD, OP_LW, 1'b0, "memrd_wait");
        cyc(1'b1, OP_LW, 1'b0, S_MEM_RD, OP_LW, "rst_mid_memrd", 1'b1);
        cyc(1'b0, OP_LW, 1'b0, S_RESET, OP_LW, "rst_from_memrd", 1'b1);
        step(S_FETCH, OP_ADDI, 1'b1, "post_rst_fetch");
        step(S_DECODE, OP_ADDI, 1'b1, "post_rst_decode");
        step(S_ADDI_EX, OP_ADDI, 1'b1, "post_rst_addi_ex");

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
